smart_bus_column_drain: RTL and testbench
=========================================

// Module: smart_bus_column_drain
// PURPOSE
//  Column-bottom collector for the systolic array: receives results from the last PE row,
//  either the vertical smart bus (bypass path) or the plain systolic bottom output.
//  Buffers captured words in a FIFO and presents them to writeback with a valid/ready handshake.
//  Sits below each array column; driven by the array controller's per-column capture strobes.
// PARAMETERS
//  WORD_SIZE   16  data word width, same as the PEs
//  FIFO_DEPTH  8   result buffer depth; power of 2, >= 2
//  CNT_WIDTH   8   width of the expected-word counter
// PORTS
//  clk                    in   1          clock
//  rst                    in   1          reset; synchronous, active-low
//  start_in               in   1          1-cycle pulse; arms a collection of expected_count_in words
//  expected_count_in      in   CNT_WIDTH  words to capture; sampled on start_in
//  capture_smart_in       in   1          capture vertical_smart_bus_in this cycle
//  capture_systolic_in    in   1          capture bottom_in this cycle
//  vertical_smart_bus_in  in   WORD_SIZE  smart bus from the last PE row
//  bottom_in              in   WORD_SIZE  systolic bottom_out of the last PE row
//  out_data               out  WORD_SIZE  FIFO head word
//  out_valid              out  1          FIFO non-empty
//  out_ready              in   1          writeback accepts out_data when out_valid & out_ready
//  busy_out               out  1          FSM not in IDLE
//  done_out               out  1          1-cycle pulse when the collection is complete and drained
//  overflow_out           out  1          sticky: a word was dropped because the FIFO was full
//  conflict_out           out  1          sticky: both capture strobes were high in one cycle
//  fifo_count_out         out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (rst==0 at posedge): FSM=IDLE, FIFO empty, remaining=0. All outputs 0; out_data=0.
//  - FSM IDLE: start_in & expected_count_in!=0 -> COLLECT; load remaining; clear overflow/conflict.
//    start_in & expected_count_in==0 -> done_out pulses next cycle, stays IDLE.
//  - COLLECT: a capture cycle is one with either strobe high. It pushes one word and decrements remaining.
//    If both strobes are high, the smart bus word is pushed, the systolic word is discarded,
//    and conflict_out is set. When remaining reaches 0 after a capture -> FLUSH.
//  - FLUSH: waits for the FIFO to empty. Then done_out pulses for 1 cycle and the FSM goes to IDLE.
//  - Captures in IDLE or FLUSH are ignored (no push, no flag). start_in while busy is ignored.
//  - FIFO is first-word fall-through. A word captured in cycle N shows on out_data/out_valid in cycle N+1.
//  - out_data changes only on a pop or on a push into an empty FIFO.
//  - Push on full with a simultaneous pop: push is accepted.
//    Push on full without a pop: word dropped, overflow_out set, remaining still decrements, so the FSM cannot hang.
//  - Pop on empty: no effect. Pointers wrap modulo FIFO_DEPTH.
//  - Reset mid-collection discards all buffered words. No done_out is generated.
// CONFIGURATION
//  SMART_DRAIN_ROWIDX_EN defined:
//   - Each FIFO entry also stores the capture index (0..expected-1, CNT_WIDTH bits).
//   - The index is exposed on an extra output out_row_idx (CNT_WIDTH), aligned with out_data.
//   - Dropped words still consume an index.
//  Macro not defined: no index storage and no out_row_idx port; behaviour otherwise identical.
// STRUCTURE
//  - Shared include smart_drain_defs.vh holds:
//    - FSM state encodings S_IDLE=2'd0, S_COLLECT=2'd1, S_FLUSH=2'd2
//    - the occupancy-width localparam.
//  - One sub-module, smart_drain_fifo: parameterised FWFT sync FIFO (width, depth) with full/empty/count.
//  - The top holds the FSM, the remaining counter, the source mux and the sticky flags.
// TESTING
//  1. Reset, then start with count=4; capture_smart with bus values 0x11,0x22,0x33,0x44, out_ready=1
//     -> out_data 0x11..0x44 in order, each 1 cycle after capture; done_out pulses once after the last pop.
//  2. count=3, captures alternate systolic/smart/systolic (0xA0,0xB0,0xC0), out_ready=0 until FLUSH
//     -> busy_out=1, fifo_count_out=3; then release ready -> words in order, done_out, busy_out=0.
//  3. FIFO_DEPTH=8, count=10, out_ready=0 -> 8 stored, 2 dropped, overflow_out=1, FSM reaches FLUSH.
//     Raise ready -> 8 pops, then done_out.
//  4. Both strobes high with smart=0x5A, systolic=0x3C -> only 0x5A is pushed, conflict_out=1,
//     remaining decrements by 1.
//  5. start with count=0 -> done_out pulses next cycle, busy_out stays 0.
//     start_in during COLLECT -> ignored, remaining unchanged.
//  6. Drop rst low while COLLECT holds 2 words -> next cycle out_valid=0, busy_out=0, flags 0, no done_out.

Source files
------------

// File: rtl/smart_bus_column_drain_pkg.sv
// Shared types for the column drain: FSM state encoding and FIFO occupancy width.
// Used by smart_bus_column_drain and smart_drain_fifo.
package smart_bus_column_drain_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2
    } drain_state_t;

    // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/smart_bus_column_drain_if.sv
// Writeback handshake of the column drain (FWFT head word, valid/ready).
// SMART_DRAIN_ROWIDX_EN adds out_row_idx, aligned with out_data.
interface smart_bus_column_drain_if #(
    parameter int WORD_SIZE = 16
`ifdef SMART_DRAIN_ROWIDX_EN
    , parameter int CNT_WIDTH = 8
`endif
);
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
`ifdef SMART_DRAIN_ROWIDX_EN
    logic [CNT_WIDTH-1:0] out_row_idx;

    modport master (output out_data, output out_valid, output out_row_idx, input out_ready);
    modport slave  (input out_data, input out_valid, input out_row_idx, output out_ready);
`else
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/smart_bus_column_drain_fifo.sv
// First-word-fall-through synchronous FIFO; a push on full is accepted only when a pop
// happens in the same cycle. Synchronous active-low reset.
module smart_drain_fifo
    import smart_bus_column_drain_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OCC_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == OCC_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;

    // Head is forced to zero when empty so out_data only moves on a pop or a push into empty.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/smart_bus_column_drain.sv
// Column-bottom collector: captures smart-bus or systolic results into a FWFT FIFO and
// drains them to writeback. Optional capture-index tagging via SMART_DRAIN_ROWIDX_EN.
//
// state     | meaning
// S_IDLE    | waiting for start_in
// S_COLLECT | capturing until the expected word count is reached
// S_FLUSH   | waiting for the FIFO to drain, then pulse done_out
module smart_bus_column_drain
    import smart_bus_column_drain_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_in,
    input  logic [CNT_WIDTH-1:0]          expected_count_in,
    input  logic                          capture_smart_in,
    input  logic                          capture_systolic_in,
    input  logic [WORD_SIZE-1:0]          vertical_smart_bus_in,
    input  logic [WORD_SIZE-1:0]          bottom_in,
    smart_bus_column_drain_if.master      wb,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          overflow_out,
    output logic                          conflict_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);
`ifdef SMART_DRAIN_ROWIDX_EN
    localparam int ENTRY_W = WORD_SIZE + CNT_WIDTH;
`else
    localparam int ENTRY_W = WORD_SIZE;
`endif

    drain_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 conflict_q, conflict_d;
    logic                 capture;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [WORD_SIZE-1:0] push_word;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;

    assign capture   = capture_smart_in | capture_systolic_in;
    // Smart bus wins when both strobes fire; the systolic word is discarded.
    assign push_word = capture_smart_in ? vertical_smart_bus_in : bottom_in;
    assign pop       = ~empty & wb.out_ready;

`ifdef SMART_DRAIN_ROWIDX_EN
    logic [CNT_WIDTH-1:0] idx_q, idx_d;

    assign push_entry     = {idx_q, push_word};
    assign wb.out_row_idx = head_entry[ENTRY_W-1:WORD_SIZE];

    // Dropped words still consume an index, so the tag always tracks capture order.
    always_comb begin
        idx_d = idx_q;
        if (state_q == S_IDLE && start_in) idx_d = '0;
        else if (state_q == S_COLLECT && capture) idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) idx_q <= '0;
        else      idx_q <= idx_d;
    end
`else
    assign push_entry = push_word;
`endif

    smart_drain_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .rd_data   (head_entry),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            conflict_q  <= conflict_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        conflict_d  = conflict_q;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (expected_count_in != '0) begin
                        state_d     = S_COLLECT;
                        remaining_d = expected_count_in;
                        overflow_d  = 1'b0;
                        conflict_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (capture) begin
                    push        = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (capture_smart_in & capture_systolic_in) conflict_d = 1'b1;
                    // Drop still counts toward remaining so the collection always terminates.
                    if (full & ~pop) overflow_d = 1'b1;
                    if (remaining_q == CNT_WIDTH'(1)) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wb.out_data   = head_entry[WORD_SIZE-1:0];
    assign wb.out_valid  = ~empty;
    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = done_q;
    assign overflow_out  = overflow_q;
    assign conflict_out  = conflict_q;

endmodule

// File: tb/tb_smart_bus_column_drain.sv
// Bench for smart_bus_column_drain: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_smart_bus_column_drain;

    localparam int WS    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_in = 1'b0;
    logic [CW-1:0] cnt_in = '0;
    logic          cs = 1'b0;
    logic          cy = 1'b0;
    logic [WS-1:0] bus = '0;
    logic [WS-1:0] bot = '0;
    logic          busy, done, ovf, cnf;
    logic [OW-1:0] fcount;

    int errors = 0;
    int checks = 0;

    smart_bus_column_drain_if #(.WORD_SIZE(WS)) wb();

    smart_bus_column_drain #(
        .WORD_SIZE  (WS),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_in              (start_in),
        .expected_count_in     (cnt_in),
        .capture_smart_in      (cs),
        .capture_systolic_in   (cy),
        .vertical_smart_bus_in (bus),
        .bottom_in             (bot),
        .wb                    (wb),
        .busy_out              (busy),
        .done_out              (done),
        .overflow_out          (ovf),
        .conflict_out          (cnf),
        .fifo_count_out        (fcount)
    );

    always #5 clk = ~clk;

    // Reference model: a word queue plus "collecting / draining" bookkeeping.
    logic [WS-1:0] mq[$];
    int  m_phase;   // 0 idle, 1 collecting, 2 draining
    int  m_left;
    bit  m_done, m_ovf, m_cnf;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop;
        bit accept;
        bit done_n;
        logic [WS-1:0] w;
        pop = 0; accept = 0; done_n = 0; w = '0;
        if (!rst) begin
            mq.delete();
            m_phase = 0; m_left = 0; m_done = 0; m_ovf = 0; m_cnf = 0;
            return;
        end
        pop = (mq.size() != 0) && wb.out_ready;
        case (m_phase)
            0: if (start_in) begin
                   if (cnt_in != 0) begin
                       m_phase = 1; m_left = int'(cnt_in); m_ovf = 0; m_cnf = 0;
                   end else done_n = 1;
               end
            1: if (cs || cy) begin
                   w = cs ? bus : bot;
                   if (cs && cy) m_cnf = 1;
                   if (mq.size() < DEPTH || pop) accept = 1;
                   else m_ovf = 1;
                   m_left--;
                   if (m_left == 0) m_phase = 2;
               end
            2: if (mq.size() == 0) begin
                   m_phase = 0; done_n = 1;
               end
            default: ;
        endcase
        if (pop) void'(mq.pop_front());
        if (accept) mq.push_back(w);
        m_done = done_n;
    endtask

    task automatic compare_model();
        chk("m_valid", int'(wb.out_valid), (mq.size() != 0) ? 1 : 0);
        chk("m_data",  int'(wb.out_data), (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("m_count", int'(fcount), mq.size());
        chk("m_busy",  int'(busy), (m_phase != 0) ? 1 : 0);
        chk("m_done",  int'(done), int'(m_done));
        chk("m_ovf",   int'(ovf), int'(m_ovf));
        chk("m_cnf",   int'(cnf), int'(m_cnf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic drive(input bit st, input int c, input bit s, input bit y,
                         input int b, input int o, input bit r);
        start_in     = st;
        cnt_in       = CW'(c);
        cs           = s;
        cy           = y;
        bus          = WS'(b);
        bot          = WS'(o);
        wb.out_ready = r;
    endtask

    typedef struct {
        bit st; int cnt; bit cs; bit cy; int bus; int bot; bit rdy;
        bit e_valid; int e_data; int e_count; bit e_busy; bit e_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        wb.out_ready = 1'b0;

        // Basic collection of 4 smart-bus words with ready held high.
        vecs.push_back('{1,4,0,0,0,0,1,     0,0,0,1,0});
        vecs.push_back('{0,0,1,0,'h11,0,1,  1,'h11,1,1,0});
        vecs.push_back('{0,0,1,0,'h22,0,1,  1,'h22,1,1,0});
        vecs.push_back('{0,0,1,0,'h33,0,1,  1,'h33,1,1,0});
        vecs.push_back('{0,0,1,0,'h44,0,1,  1,'h44,1,1,0});
        vecs.push_back('{0,0,0,0,0,0,1,     0,0,0,1,0});
        vecs.push_back('{0,0,0,0,0,0,1,     0,0,0,0,1});
        vecs.push_back('{0,0,0,0,0,0,1,     0,0,0,0,0});
        // Captures in idle are ignored.
        vecs.push_back('{0,0,1,1,'h99,'h88,1, 0,0,0,0,0});
        // Zero-length start.
        vecs.push_back('{1,0,0,0,0,0,1,     0,0,0,0,1});
        vecs.push_back('{0,0,0,0,0,0,1,     0,0,0,0,0});
        // Start while collecting must not reload remaining.
        vecs.push_back('{1,2,0,0,0,0,1,     0,0,0,1,0});
        vecs.push_back('{1,5,0,0,0,0,1,     0,0,0,1,0});
        vecs.push_back('{0,0,1,0,'h66,0,1,  1,'h66,1,1,0});
        vecs.push_back('{0,0,1,0,'h77,0,1,  1,'h77,1,1,0});
        vecs.push_back('{0,0,0,0,0,0,1,     0,0,0,1,0});
        vecs.push_back('{0,0,0,0,0,0,1,     0,0,0,0,1});

        // Reset
        drive(0,0,0,0,0,0,0);
        rst = 1'b0;
        repeat (2) step();
        chk("rst_valid", int'(wb.out_valid), 0);
        chk("rst_data", int'(wb.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].cnt, vecs[i].cs, vecs[i].cy,
                  vecs[i].bus, vecs[i].bot, vecs[i].rdy);
            step();
            chk($sformatf("v%0d_valid", i), int'(wb.out_valid), int'(vecs[i].e_valid));
            chk($sformatf("v%0d_data", i),  int'(wb.out_data), vecs[i].e_data);
            chk($sformatf("v%0d_count", i), int'(fcount), vecs[i].e_count);
            chk($sformatf("v%0d_busy", i),  int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i),  int'(done), int'(vecs[i].e_done));
        end

        // Alternating sources held back by ready, then drained in order.
        drive(1,3,0,0,0,0,0);       step();
        drive(0,0,0,1,0,'hA0,0);    step();
        drive(0,0,1,0,'hB0,0,0);    step();
        drive(0,0,0,1,0,'hC0,0);    step();
        chk("alt_count", int'(fcount), 3);
        chk("alt_busy", int'(busy), 1);
        chk("alt_head", int'(wb.out_data), 'hA0);
        drive(0,0,0,0,0,0,1);       step();
        chk("alt_pop1", int'(wb.out_data), 'hB0);
        step();
        chk("alt_pop2", int'(wb.out_data), 'hC0);
        step();
        chk("alt_empty", int'(wb.out_valid), 0);
        step();
        chk("alt_done", int'(done), 1);
        chk("alt_idle", int'(busy), 0);

        // Overflow: 10 words into an 8-deep FIFO with ready low.
        drive(1,10,0,0,0,0,0);      step();
        for (int k = 0; k < 10; k++) begin
            drive(0,0,1,0,k+1,0,0);
            step();
        end
        chk("ovf_count", int'(fcount), 8);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_busy", int'(busy), 1);
        drive(0,0,0,0,0,0,1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_pop%0d", k), int'(wb.out_data), k + 1);
            step();
        end
        chk("ovf_drained", int'(fcount), 0);
        step();
        chk("ovf_done", int'(done), 1);

        // Conflict: smart word wins, one decrement per cycle.
        drive(1,2,0,0,0,0,0);          step();
        drive(0,0,1,1,'h5A,'h3C,0);    step();
        chk("cnf_data", int'(wb.out_data), 'h5A);
        chk("cnf_count", int'(fcount), 1);
        chk("cnf_flag", int'(cnf), 1);
        drive(0,0,0,1,0,'h3C,0);       step();
        chk("cnf_count2", int'(fcount), 2);
        drive(0,0,1,0,'hEE,0,0);       step();
        chk("flush_ignore", int'(fcount), 2);
        drive(0,0,0,0,0,0,1);          step();
        chk("cnf_pop", int'(wb.out_data), 'h3C);
        step();
        step();
        chk("cnf_done", int'(done), 1);

        // Reset mid-collection with two buffered words and a sticky flag.
        drive(1,4,0,0,0,0,0);          step();
        drive(0,0,1,1,'h12,'h34,0);    step();
        drive(0,0,1,0,'h56,0,0);       step();
        chk("pre_rst_count", int'(fcount), 2);
        drive(0,0,0,0,0,0,0);
        rst = 1'b0;                    step();
        chk("mrst_valid", int'(wb.out_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_cnf", int'(cnf), 0);
        chk("mrst_done", int'(done), 0);
        rst = 1'b1;                    step();
        chk("mrst_done2", int'(done), 0);

        // Randomized run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 299) != 0);
            start_in     = ($urandom_range(0, 11) == 0);
            cnt_in       = CW'($urandom_range(0, 12));
            cs           = ($urandom_range(0, 2) == 0);
            cy           = ($urandom_range(0, 3) == 0);
            bus          = WS'($urandom);
            bot          = WS'($urandom);
            wb.out_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                : ($urandom_range(0, 4) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
